// File: rtl/branch_update_ctrl.sv
// ---------------------------------------------------------------------------
// branch_update_ctrl
//
// Arbitrates between the two branch-resolution units of the out-of-order
// backend and the single predictor-update / redirect port of the PC stage.
//   - Exceptions win over everything: they flush the PC stage, drop all
//     queued training updates and open a front-end flush window.
//   - Mispredicts (br0 before br1) are sent straight to the PC stage as a
//     redirect and open a flush window.
//   - Correctly predicted branches are queued in a small FIFO and drained
//     one per cycle whenever no redirect or exception owns the port.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   brN_valid / brN_ready    resolved-branch handshake (port 0 is older)
//   brN_is_jump/is_taken/is_miss/pht_index/pc/target   request payload
//   exc_valid, exc_pc        exception / eret redirect request
//   is_*_out, last_pht_index_out, inst_pc_out, target_out
//                            registered predictor-update port to PC stage
//   pc_flush_out, exc_pc_out registered exception redirect to PC stage
//   pipe_flush_out           registered flush for PCIF/IF pipeline registers
// ---------------------------------------------------------------------------
module branch_update_ctrl #(
    parameter int GHR_WIDTH    = 5,
    parameter int FIFO_DEPTH   = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 br0_valid,
    output logic                 br0_ready,
    input  logic                 br0_is_jump,
    input  logic                 br0_is_taken,
    input  logic                 br0_is_miss,
    input  logic [GHR_WIDTH-1:0] br0_pht_index,
    input  logic [31:0]          br0_pc,
    input  logic [31:0]          br0_target,

    input  logic                 br1_valid,
    output logic                 br1_ready,
    input  logic                 br1_is_jump,
    input  logic                 br1_is_taken,
    input  logic                 br1_is_miss,
    input  logic [GHR_WIDTH-1:0] br1_pht_index,
    input  logic [31:0]          br1_pc,
    input  logic [31:0]          br1_target,

    input  logic                 exc_valid,
    input  logic [31:0]          exc_pc,

    output logic                 is_branch_out,
    output logic                 is_jump_out,
    output logic                 is_taken_out,
    output logic                 is_miss_out,
    output logic [GHR_WIDTH-1:0] last_pht_index_out,
    output logic [31:0]          inst_pc_out,
    output logic [31:0]          target_out,
    output logic                 pc_flush_out,
    output logic [31:0]          exc_pc_out,
    output logic                 pipe_flush_out
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int ENTRY_W = 2 + GHR_WIDTH + 64;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    // Ready only while at least two entries are free, so a dual push can
    // never overflow.
    localparam logic [CNT_W-1:0] READY_MAX  = CNT_W'(FIFO_DEPTH - 2);
    localparam logic [FC_W-1:0]  FLUSH_LAST = FC_W'(FLUSH_CYCLES - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]           state_reg,     state_next;
    logic [FC_W-1:0]      flush_cnt_reg, flush_cnt_next;
    logic [PTR_W-1:0]     wr_ptr_reg,    wr_ptr_next;
    logic [PTR_W-1:0]     rd_ptr_reg,    rd_ptr_next;
    logic [CNT_W-1:0]     count_reg,     count_next;

    logic                 is_branch_reg,  is_branch_next;
    logic                 is_jump_reg,    is_jump_next;
    logic                 is_taken_reg,   is_taken_next;
    logic                 is_miss_reg,    is_miss_next;
    logic [GHR_WIDTH-1:0] pht_index_reg,  pht_index_next;
    logic [31:0]          inst_pc_reg,    inst_pc_next;
    logic [31:0]          target_reg,     target_next;
    logic                 pc_flush_reg,   pc_flush_next;
    logic [31:0]          exc_pc_reg,     exc_pc_next;
    logic                 pipe_flush_reg, pipe_flush_next;

    // ------------------------------------------------------------------
    // Handshake and per-cycle winner selection
    // ------------------------------------------------------------------
    logic br_ready;
    logic acc0, acc1;
    logic redir0, redir1;
    logic push0, push1;
    logic do_pop;

    assign br_ready  = (state_reg == ST_IDLE) && !exc_valid && (count_reg <= READY_MAX);
    assign br0_ready = br_ready;
    assign br1_ready = br_ready;

    assign acc0   = br0_valid && br_ready;
    assign acc1   = br1_valid && br_ready;
    assign redir0 = !exc_valid && acc0 && br0_is_miss;
    // A br0 miss makes br1 a wrong-path instruction: it is neither
    // redirected nor trained.
    assign redir1 = !exc_valid && !redir0 && acc1 && br1_is_miss;
    assign push0  = !exc_valid && acc0 && !br0_is_miss;
    assign push1  = !exc_valid && !redir0 && acc1 && !br1_is_miss;
    // count_reg is registered state, so an entry pushed this cycle cannot
    // be popped before the next one.
    assign do_pop = !exc_valid && !redir0 && !redir1 && (count_reg != '0);

    // ------------------------------------------------------------------
    // Training FIFO storage
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] br0_entry, br1_entry, head_entry;
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr1_addr;

    assign br0_entry  = {br0_is_jump, br0_is_taken, br0_pht_index, br0_pc, br0_target};
    assign br1_entry  = {br1_is_jump, br1_is_taken, br1_pht_index, br1_pc, br1_target};
    // br1 lands behind br0 when both push in the same cycle.
    assign wr1_addr   = push0 ? (wr_ptr_reg + PTR_W'(1)) : wr_ptr_reg;
    assign head_entry = fifo_mem[rd_ptr_reg];

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [ENTRY_W-1:0] entry_reg;

            // Payload needs no reset: validity is tracked by count_reg.
            always_ff @(posedge clk) begin
                if (push0 && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg <= br0_entry;
                end else if (push1 && (wr1_addr == PTR_W'(gi))) begin
                    entry_reg <= br1_entry;
                end
            end

            assign fifo_mem[gi] = entry_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // FIFO pointer / occupancy update
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (exc_valid) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(push0) + PTR_W'(push1);
            rd_ptr_next = rd_ptr_reg + PTR_W'(do_pop);
            count_next  = count_reg + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(do_pop);
        end
    end

    // ------------------------------------------------------------------
    // FSM and flush window
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        flush_cnt_next  = flush_cnt_reg;
        pipe_flush_next = 1'b0;
        if (exc_valid || redir0 || redir1) begin
            // First flush cycle is the registered output of this cycle; the
            // counter covers the remaining FLUSH_CYCLES-1.
            state_next      = ST_FLUSH;
            flush_cnt_next  = FLUSH_LAST;
            pipe_flush_next = 1'b1;
        end else if (state_reg == ST_FLUSH) begin
            if (flush_cnt_reg == '0) begin
                state_next = ST_IDLE;
            end else begin
                flush_cnt_next  = flush_cnt_reg - FC_W'(1);
                pipe_flush_next = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // PC-stage port next values
    // ------------------------------------------------------------------
    always_comb begin
        is_branch_next = 1'b0;
        is_jump_next   = 1'b0;
        is_taken_next  = 1'b0;
        is_miss_next   = 1'b0;
        pht_index_next = '0;
        inst_pc_next   = '0;
        target_next    = '0;
        pc_flush_next  = 1'b0;
        exc_pc_next    = '0;
        if (exc_valid) begin
            pc_flush_next = 1'b1;
            exc_pc_next   = exc_pc;
        end else if (redir0) begin
            is_branch_next = 1'b1;
            is_miss_next   = 1'b1;
            is_jump_next   = br0_is_jump;
            is_taken_next  = br0_is_taken;
            pht_index_next = br0_pht_index;
            inst_pc_next   = br0_pc;
            target_next    = br0_target;
        end else if (redir1) begin
            is_branch_next = 1'b1;
            is_miss_next   = 1'b1;
            is_jump_next   = br1_is_jump;
            is_taken_next  = br1_is_taken;
            pht_index_next = br1_pht_index;
            inst_pc_next   = br1_pc;
            target_next    = br1_target;
        end else if (do_pop) begin
            is_branch_next = 1'b1;
            {is_jump_next, is_taken_next, pht_index_next, inst_pc_next, target_next} = head_entry;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            flush_cnt_reg  <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            is_branch_reg  <= 1'b0;
            is_jump_reg    <= 1'b0;
            is_taken_reg   <= 1'b0;
            is_miss_reg    <= 1'b0;
            pht_index_reg  <= '0;
            inst_pc_reg    <= '0;
            target_reg     <= '0;
            pc_flush_reg   <= 1'b0;
            exc_pc_reg     <= '0;
            pipe_flush_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            flush_cnt_reg  <= flush_cnt_next;
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            is_branch_reg  <= is_branch_next;
            is_jump_reg    <= is_jump_next;
            is_taken_reg   <= is_taken_next;
            is_miss_reg    <= is_miss_next;
            pht_index_reg  <= pht_index_next;
            inst_pc_reg    <= inst_pc_next;
            target_reg     <= target_next;
            pc_flush_reg   <= pc_flush_next;
            exc_pc_reg     <= exc_pc_next;
            pipe_flush_reg <= pipe_flush_next;
        end
    end

    assign is_branch_out      = is_branch_reg;
    assign is_jump_out        = is_jump_reg;
    assign is_taken_out       = is_taken_reg;
    assign is_miss_out        = is_miss_reg;
    assign last_pht_index_out = pht_index_reg;
    assign inst_pc_out        = inst_pc_reg;
    assign target_out         = target_reg;
    assign pc_flush_out       = pc_flush_reg;
    assign exc_pc_out         = exc_pc_reg;
    assign pipe_flush_out     = pipe_flush_reg;

endmodule

// File: tb/tb_branch_update_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_update_ctrl
//
// Directed stimulus with a scoreboard: every expected PC-stage transaction
// is queued when the stimulus is issued, and a monitor compares it whenever
// the DUT presents an update (is_branch_out) or an exception (pc_flush_out).
// Flush-window and readiness timing are checked inline by the stimulus.
// ---------------------------------------------------------------------------
module tb_branch_update_ctrl;

    localparam int GW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          br0_valid, br0_ready, br0_is_jump, br0_is_taken, br0_is_miss;
    logic [GW-1:0] br0_pht_index;
    logic [31:0]   br0_pc, br0_target;
    logic          br1_valid, br1_ready, br1_is_jump, br1_is_taken, br1_is_miss;
    logic [GW-1:0] br1_pht_index;
    logic [31:0]   br1_pc, br1_target;
    logic          exc_valid;
    logic [31:0]   exc_pc;
    logic          is_branch_out, is_jump_out, is_taken_out, is_miss_out;
    logic [GW-1:0] last_pht_index_out;
    logic [31:0]   inst_pc_out, target_out;
    logic          pc_flush_out;
    logic [31:0]   exc_pc_out;
    logic          pipe_flush_out;

    always #5 clk = ~clk;

    branch_update_ctrl #(
        .GHR_WIDTH   (GW),
        .FIFO_DEPTH  (4),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .br0_valid         (br0_valid),
        .br0_ready         (br0_ready),
        .br0_is_jump       (br0_is_jump),
        .br0_is_taken      (br0_is_taken),
        .br0_is_miss       (br0_is_miss),
        .br0_pht_index     (br0_pht_index),
        .br0_pc            (br0_pc),
        .br0_target        (br0_target),
        .br1_valid         (br1_valid),
        .br1_ready         (br1_ready),
        .br1_is_jump       (br1_is_jump),
        .br1_is_taken      (br1_is_taken),
        .br1_is_miss       (br1_is_miss),
        .br1_pht_index     (br1_pht_index),
        .br1_pc            (br1_pc),
        .br1_target        (br1_target),
        .exc_valid         (exc_valid),
        .exc_pc            (exc_pc),
        .is_branch_out     (is_branch_out),
        .is_jump_out       (is_jump_out),
        .is_taken_out      (is_taken_out),
        .is_miss_out       (is_miss_out),
        .last_pht_index_out(last_pht_index_out),
        .inst_pc_out       (inst_pc_out),
        .target_out        (target_out),
        .pc_flush_out      (pc_flush_out),
        .exc_pc_out        (exc_pc_out),
        .pipe_flush_out    (pipe_flush_out)
    );

    typedef struct packed {
        logic          exc;
        logic          jump;
        logic          taken;
        logic          miss;
        logic [GW-1:0] idx;
        logic [31:0]   pc;
        logic [31:0]   tgt;
        logic [31:0]   exc_pc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic exp_branch(input logic jump, input logic taken, input logic miss,
                              input logic [GW-1:0] idx, input logic [31:0] pc, input logic [31:0] tgt);
        exp_t e;
        e = '0;
        e.jump = jump; e.taken = taken; e.miss = miss;
        e.idx = idx; e.pc = pc; e.tgt = tgt;
        exp_q.push_back(e);
    endtask

    task automatic exp_exc(input logic [31:0] epc);
        exp_t e;
        e = '0;
        e.exc = 1'b1;
        e.exc_pc = epc;
        exp_q.push_back(e);
    endtask

    task automatic set_br0(input logic jump, input logic taken, input logic miss,
                           input logic [GW-1:0] idx, input logic [31:0] pc, input logic [31:0] tgt);
        br0_valid = 1'b1; br0_is_jump = jump; br0_is_taken = taken; br0_is_miss = miss;
        br0_pht_index = idx; br0_pc = pc; br0_target = tgt;
    endtask

    task automatic set_br1(input logic jump, input logic taken, input logic miss,
                           input logic [GW-1:0] idx, input logic [31:0] pc, input logic [31:0] tgt);
        br1_valid = 1'b1; br1_is_jump = jump; br1_is_taken = taken; br1_is_miss = miss;
        br1_pht_index = idx; br1_pc = pc; br1_target = tgt;
    endtask

    task automatic clear_inputs();
        br0_valid = 1'b0;
        br1_valid = 1'b0;
        exc_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (is_branch_out === 1'b1 || pc_flush_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got branch=%0b pc_flush=%0b pc=%h target=%h, required no transaction",
                             is_branch_out, pc_flush_out, inst_pc_out, target_out);
                end else begin
                    e = exp_q.pop_front();
                    if (e.exc) begin
                        $display("txn exception exc_pc=%h", exc_pc_out);
                        check("exception_txn",
                              128'({is_branch_out, is_jump_out, is_taken_out, is_miss_out, pc_flush_out, exc_pc_out}),
                              128'({4'b0000, 1'b1, e.exc_pc}));
                    end else begin
                        $display("txn update miss=%0b jump=%0b taken=%0b idx=%0d pc=%h target=%h",
                                 is_miss_out, is_jump_out, is_taken_out, last_pht_index_out, inst_pc_out, target_out);
                        check("update_txn",
                              128'({is_branch_out, is_jump_out, is_taken_out, is_miss_out,
                                    last_pht_index_out, inst_pc_out, target_out, pc_flush_out}),
                              128'({1'b1, e.jump, e.taken, e.miss, e.idx, e.pc, e.tgt, 1'b0}));
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        br0_is_jump = 0; br0_is_taken = 0; br0_is_miss = 0; br0_pht_index = '0; br0_pc = '0; br0_target = '0;
        br1_is_jump = 0; br1_is_taken = 0; br1_is_miss = 0; br1_pht_index = '0; br1_pc = '0; br1_target = '0;
        exc_pc = '0;

        // Reset with every request asserted
        rst = 1'b1;
        exc_valid = 1'b1;
        exc_pc = 32'hdeadbeef;
        set_br0(1, 1, 1, 5'h1f, 32'h1111_0000, 32'h2222_0000);
        set_br1(1, 1, 0, 5'h0a, 32'h3333_0000, 32'h4444_0000);
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_outputs",
                  128'({is_branch_out, is_jump_out, is_taken_out, is_miss_out, last_pht_index_out,
                        inst_pc_out, target_out, pc_flush_out, exc_pc_out, pipe_flush_out}),
                  128'(0));
            check("reset_ready", 128'({br0_ready, br1_ready}), 128'(0));
        end
        rst = 1'b0;
        clear_inputs();
        #1;
        check("ready_after_reset", 128'({br0_ready, br1_ready}), 128'(2'b11));

        // br0 mispredict: redirect and a 2-cycle flush window
        set_br0(0, 1, 1, 5'd3, 32'hbfc00010, 32'hbfc00000);
        exp_branch(0, 1, 1, 5'd3, 32'hbfc00010, 32'hbfc00000);
        step();
        clear_inputs();
        check("redir_pipe_flush_c1", 128'(pipe_flush_out), 128'(1));
        check("redir_pc_flush_c1", 128'(pc_flush_out), 128'(0));
        check("redir_ready_c1", 128'({br0_ready, br1_ready}), 128'(0));
        step();
        check("redir_pipe_flush_c2", 128'(pipe_flush_out), 128'(1));
        check("redir_pc_flush_c2", 128'(pc_flush_out), 128'(0));
        check("redir_ready_c2", 128'({br0_ready, br1_ready}), 128'(0));
        step();
        check("redir_pipe_flush_end", 128'(pipe_flush_out), 128'(0));
        check("redir_ready_end", 128'({br0_ready, br1_ready}), 128'(2'b11));

        // Dual training pushes for two cycles: order 0x100,0x200,0x100,0x200
        set_br0(0, 0, 0, 5'd1, 32'h0000_0100, 32'h0000_0104);
        set_br1(1, 1, 0, 5'd2, 32'h0000_0200, 32'h0000_0204);
        exp_branch(0, 0, 0, 5'd1, 32'h0000_0100, 32'h0000_0104);
        exp_branch(1, 1, 0, 5'd2, 32'h0000_0200, 32'h0000_0204);
        step();
        check("train_ready_cnt2", 128'({br0_ready, br1_ready}), 128'(2'b11));
        exp_branch(0, 0, 0, 5'd1, 32'h0000_0100, 32'h0000_0104);
        exp_branch(1, 1, 0, 5'd2, 32'h0000_0200, 32'h0000_0204);
        step();
        clear_inputs();
        check("train_ready_cnt3", 128'({br0_ready, br1_ready}), 128'(0));
        check("train_no_pipe_flush", 128'(pipe_flush_out), 128'(0));
        step();
        check("train_ready_drain", 128'({br0_ready, br1_ready}), 128'(2'b11));
        step();
        step();
        step();

        // Both ports miss: only br0 redirects
        set_br0(0, 1, 1, 5'd7, 32'h0000_0300, 32'h0000_0400);
        set_br1(0, 1, 1, 5'd9, 32'h0000_0304, 32'h0000_0500);
        exp_branch(0, 1, 1, 5'd7, 32'h0000_0300, 32'h0000_0400);
        step();
        clear_inputs();
        step();
        step();
        check("dual_miss_ready_end", 128'({br0_ready, br1_ready}), 128'(2'b11));

        // br0 trains, br1 misses: redirect first, then the queued training
        set_br0(0, 0, 0, 5'd4, 32'h0000_0600, 32'h0000_0604);
        set_br1(1, 1, 1, 5'd5, 32'h0000_0608, 32'h0000_0700);
        exp_branch(1, 1, 1, 5'd5, 32'h0000_0608, 32'h0000_0700);
        exp_branch(0, 0, 0, 5'd4, 32'h0000_0600, 32'h0000_0604);
        step();
        clear_inputs();
        check("br1_miss_pipe_flush", 128'(pipe_flush_out), 128'(1));
        step();
        check("br1_miss_pop_in_flush", 128'(pipe_flush_out), 128'(1));
        step();
        check("br1_miss_ready_end", 128'({br0_ready, br1_ready}), 128'(2'b11));

        // Three updates queued, then an exception discards them
        set_br0(0, 1, 0, 5'd11, 32'h0000_0a00, 32'h0000_0a04);
        set_br1(0, 0, 0, 5'd12, 32'h0000_0b00, 32'h0000_0b04);
        exp_branch(0, 1, 0, 5'd11, 32'h0000_0a00, 32'h0000_0a04);
        step();
        set_br0(1, 1, 0, 5'd13, 32'h0000_0c00, 32'h0000_0c04);
        set_br1(0, 1, 0, 5'd14, 32'h0000_0d00, 32'h0000_0d04);
        step();
        clear_inputs();
        exc_valid = 1'b1;
        exc_pc = 32'hbfc00380;
        set_br0(0, 1, 1, 5'd15, 32'h0000_0e00, 32'h0000_0f00);
        exp_exc(32'hbfc00380);
        step();
        clear_inputs();
        check("exc_pipe_flush_c1", 128'(pipe_flush_out), 128'(1));
        check("exc_pc_flush_c1", 128'(pc_flush_out), 128'(1));
        step();
        check("exc_pc_flush_c2", 128'(pc_flush_out), 128'(0));
        check("exc_pipe_flush_c2", 128'(pipe_flush_out), 128'(1));
        step();
        check("exc_pipe_flush_end", 128'(pipe_flush_out), 128'(0));
        check("exc_ready_end", 128'({br0_ready, br1_ready}), 128'(2'b11));
        step();
        step();
        step();

        // Exception on the second cycle of a mispredict flush restarts it
        set_br0(0, 0, 1, 5'd10, 32'h0000_0800, 32'h0000_0900);
        exp_branch(0, 0, 1, 5'd10, 32'h0000_0800, 32'h0000_0900);
        step();
        clear_inputs();
        check("restart_pipe_flush_c1", 128'(pipe_flush_out), 128'(1));
        step();
        exc_valid = 1'b1;
        exc_pc = 32'hbfc00400;
        exp_exc(32'hbfc00400);
        step();
        clear_inputs();
        check("restart_pipe_flush_r1", 128'(pipe_flush_out), 128'(1));
        check("restart_pc_flush_r1", 128'(pc_flush_out), 128'(1));
        step();
        check("restart_pipe_flush_r2", 128'(pipe_flush_out), 128'(1));
        check("restart_pc_flush_r2", 128'(pc_flush_out), 128'(0));
        check("restart_ready_r2", 128'({br0_ready, br1_ready}), 128'(0));
        step();
        check("restart_pipe_flush_end", 128'(pipe_flush_out), 128'(0));
        check("restart_ready_end", 128'({br0_ready, br1_ready}), 128'(2'b11));

        step();
        step();
        step();
        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_update_ctrl.md
Name: branch_update_ctrl

Overview:
- Scheduler between the out-of-order backend's two branch-resolution units and the PC stage's single predictor-update/redirect port (is_branch/is_jump/is_taken/is_miss/last_pht_index/inst_pc/target).
- Queues correct-prediction training updates in a small FIFO and serialises them one per cycle.
- Gives mispredict redirects priority over training, and exceptions priority over everything.
- Sequences the front-end flush window that follows a redirect.

Parameters:
- GHR_WIDTH, 5, width of the PHT index; must equal the `GHR_BUS width.
- FIFO_DEPTH, 4, training-update queue entries; power of two, at least 2.
- FLUSH_CYCLES, 2, cycles pipe_flush_out stays high after a redirect; at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- br0_valid / br1_valid  in  1  resolved-branch request; port 0 is older in program order
- br0_ready / br1_ready  out  1  request accepted this cycle when valid and ready are both high
- brN_is_jump  in  1  unconditional jump
- brN_is_taken  in  1  actual direction
- brN_is_miss  in  1  prediction was wrong
- brN_pht_index  in  GHR_WIDTH  PHT index carried from fetch
- brN_pc  in  32  branch instruction PC
- brN_target  in  32  resolved next PC
- exc_valid  in  1  exception/eret redirect request
- exc_pc  in  32  exception handler PC
- is_branch_out, is_jump_out, is_taken_out, is_miss_out  out  1  to the PC stage update port
- last_pht_index_out  out  GHR_WIDTH  to the PC stage
- inst_pc_out  out  32  to the PC stage
- target_out  out  32  to the PC stage
- pc_flush_out  out  1  PC-stage flush (selects exc_pc_out)
- exc_pc_out  out  32  to the PC stage
- pipe_flush_out  out  1  flush for PCIF/IF pipeline registers

Behaviour:
- All outputs are registered. Every output resets to 0, the FSM resets to IDLE, the FIFO resets empty, and the flush counter resets to 0. Reset overrides all other inputs in the same cycle.
- FSM states are IDLE and FLUSH. A flush counter counts down from FLUSH_CYCLES.
- Readiness:
  - brN_ready is high only in IDLE, with exc_valid low, and with at least 2 free FIFO entries (so both ports can always push together).
  - brN_ready is purely a function of registered state plus exc_valid.
- Priority per cycle, highest first: exc_valid, then accepted br0 miss, then accepted br1 miss, then FIFO pop.
- Exception (exc_valid, from any state), outputs at t+1:
  - pc_flush_out=1, pipe_flush_out=1, exc_pc_out=exc_pc, all is_*_out=0.
  - FIFO cleared; any same-cycle branch requests discarded.
  - FSM goes to FLUSH with counter=FLUSH_CYCLES-1.
  - An exception arriving during FLUSH restarts the window with the new exc_pc.
- Mispredict (accepted brN with is_miss=1, winning priority), outputs at t+1:
  - is_branch_out=1, is_miss_out=1; is_jump/is_taken/pht_index/pc/target copied from the request.
  - pipe_flush_out=1, pc_flush_out=0.
  - FSM goes to FLUSH. FIFO contents are kept.
  - If br0 misses, the same-cycle br1 request is dropped entirely (younger, wrong path).
  - If br1 misses, a same-cycle br0 non-miss request is pushed into the FIFO.
- Training (accepted, is_miss=0):
  - Pushed to the FIFO; when both ports push in one cycle, br0 is enqueued first.
  - On a cycle with no exception or redirect winner and a non-empty FIFO, the head is popped and driven at t+1 with is_branch_out=1, is_miss_out=0.
  - A push into an empty FIFO can pop no earlier than the next cycle (no bypass).
- FLUSH state:
  - pipe_flush_out stays high for exactly FLUSH_CYCLES consecutive cycles, then the FSM returns to IDLE.
  - Branch ports are not ready; branch requests presented in FLUSH are never accepted and produce no effect.
  - FIFO pops continue after the redirect cycle.
- A cycle with no winner drives all is_*_out=0 and leaves target_out/inst_pc_out at don't-care (drive 0).
- FIFO pointers wrap modulo FIFO_DEPTH. A count register distinguishes full from empty. Overflow is impossible by the ready rule.

Test Plan:
- Reset for 3 cycles with all valids high → all outputs 0, readies 0 during reset; first cycle after reset, br0_ready=br1_ready=1.
- br0 {pc=0xbfc00010, target=0xbfc00000, is_taken=1, is_miss=1, pht_index=3} → next cycle is_miss_out=1, target_out=0xbfc00000, inst_pc_out=0xbfc00010, last_pht_index_out=3. pipe_flush_out high for exactly 2 cycles, pc_flush_out stays 0, readies low for 2 cycles.
- Both ports push non-miss updates (pc 0x100, then 0x200) for 2 cycles → inst_pc_out sequence 0x100, 0x200, 0x100, 0x200. Readies drop when fewer than 2 entries are free.
- br0 miss and br1 miss in the same cycle → only br0's target is emitted and br1 is dropped. Swapped case (br0 non-miss, br1 miss) → br1 redirect first, br0 training popped afterwards.
- 3 updates queued, then exc_valid with exc_pc=0xbfc00380 → next cycle pc_flush_out=1, exc_pc_out=0xbfc00380, no queued update is ever emitted.
- exc_valid asserted on the 2nd cycle of a mispredict flush → flush window restarts; pipe_flush_out high for 2 further cycles, pc_flush_out=1 for one cycle.
